shift_right_seq: RTL and testbench

- Multi-cycle 32-bit right shifter for the MIPS datapath: logical (SRL/SRLV) and arithmetic (SRA/SRAV).
- It is the right-direction counterpart of the combinational left shifter.
- It shifts one bit position per clock and returns the result over a valid/ready handshake.
- It serves the ALU/multi-cycle execution path where area matters more than shift latency.

---
 rtl/shift_right_seq.sv | 118 +++++++++++
 tb/tb_shift_right_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
//
// Multi-cycle right shifter for the MIPS datapath. It handles logical shifts
// (SRL/SRLV, zero fill) and arithmetic shifts (SRA/SRAV, sign fill). The
// operand moves one bit position per clock. The result is returned over a
// valid/ready handshake. This unit trades shift latency for area.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   START      request strobe, accepted only while IN_READY=1
//   A          operand, sampled on accept
//   B          shift amount source; only B[SHW-1:0] is used
//   ARITH      1 = sign fill, 0 = zero fill, sampled on accept
//   IN_READY   high exactly when the unit is idle
//   R          result register
//   VALID      R holds a completed result
//   OUT_READY  consumer accepts R while VALID=1
//
// Handshake: a request transfers on a rising edge where START=1 and
// IN_READY=1. A result transfers on a rising edge where VALID=1 and
// OUT_READY=1. Once VALID is asserted, it and R stay stable until that
// transfer edge.
//
// Latency: the accepting edge counts as edge 1. VALID is observed after
// shamt+1 edges, where shamt = B[SHW-1:0].
// -----------------------------------------------------------------------------
module shift_right_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ARITH,
    output logic             IN_READY,
    output logic [WIDTH-1:0] R,
    output logic             VALID,
    input  logic             OUT_READY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             fill_q, fill_d;

    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   count_one;

    // MIPS ignores the upper bits of the shift-amount register.
    logic             unused_b_hi;

    assign shamt       = B[SHW-1:0];
    assign count_one   = {{(SHW-1){1'b0}}, 1'b1};
    assign unused_b_hi = ^B[WIDTH-1:SHW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            count_q <= count_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        count_d = count_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    r_d     = A;
                    count_d = shamt;
                    // The fill bit is captured once here and reused on every step.
                    fill_d  = ARITH & A[WIDTH-1];
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                r_d     = {fill_q, r_q[WIDTH-1:1]};
                count_d = count_q - count_one;
                if (count_q == count_one) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // START is ignored here, even when it arrives with OUT_READY.
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign IN_READY = (state_q == IDLE);
    assign VALID    = (state_q == DONE);
    assign R        = r_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_right_seq
//
// Directed and randomised bench for shift_right_seq.
// The driver pushes the expected result and expected latency into queues.
// The monitor checks each result as the DUT presents it.
// -----------------------------------------------------------------------------
module tb_shift_right_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ARITH;
    logic             IN_READY;
    logic [WIDTH-1:0] R;
    logic             VALID;
    logic             OUT_READY;

    shift_right_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .START     (START),
        .A         (A),
        .B         (B),
        .ARITH     (ARITH),
        .IN_READY  (IN_READY),
        .R         (R),
        .VALID     (VALID),
        .OUT_READY (OUT_READY)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Output-ready policy: 0 = always ready, 1 = random, 2 = held low.
    int bp_mode = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               lat_q[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       OUT_READY = 1'b1;
                1:       OUT_READY = 1'($urandom_range(0, 1));
                default: OUT_READY = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int               cyc;
        int               acc_cyc;
        logic             valid_prev;
        logic [WIDTH-1:0] r_prev;
        bit               chk_idle;
        cyc        = 0;
        acc_cyc    = 0;
        valid_prev = 1'b0;
        r_prev     = '0;
        chk_idle   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                valid_prev = 1'b0;
                chk_idle   = 1'b0;
            end else begin
                if (chk_idle) begin
                    check("idle_after_xfer", {30'd0, IN_READY, VALID}, 32'h2);
                    chk_idle = 1'b0;
                end
                if (START && IN_READY) acc_cyc = cyc;
                if (VALID) begin
                    if (exp_q.size() == 0) begin
                        if (!valid_prev) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_valid: got R=0x%08h expected no result", R);
                        end
                    end else begin
                        if (!valid_prev) begin
                            check("latency", 32'(cyc - acc_cyc), 32'(lat_q[0]));
                            check("result", R, exp_q[0]);
                        end else begin
                            check("r_stable", R, r_prev);
                        end
                        if (OUT_READY) begin
                            void'(exp_q.pop_front());
                            void'(lat_q.pop_front());
                            chk_idle = 1'b1;
                        end
                    end
                end
                valid_prev = VALID;
                r_prev     = R;
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic wait_ready();
        int guard;
        guard = 0;
        while (IN_READY !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_ready_timeout: got IN_READY=%0b expected 1", IN_READY);
        end
    endtask

    task automatic start_raw(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ar);
        START = 1'b1;
        A     = a;
        B     = b;
        ARITH = ar;
        @(posedge clk);
        #1;
        START = 1'b0;
        // Operands may change freely once accepted.
        A     = $urandom;
        B     = $urandom;
        ARITH = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ar,
                         input logic [WIDTH-1:0] exp);
        wait_ready();
        exp_q.push_back(exp);
        lat_q.push_back(int'(b[SHW-1:0]) + 1);
        start_raw(a, b, ar);
    endtask

    // Requests that must be ignored because the unit is busy.
    task automatic pulse_junk();
        START = 1'b1;
        A     = 32'h1;
        B     = 32'h1;
        ARITH = 1'b0;
        @(posedge clk);
        #1;
        START = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || IN_READY !== 1'b1) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ar;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin : stim
        int guard;
        logic [WIDTH-1:0] ra, rb, rexp;
        logic             rar;

        vecs[0] = '{32'h8000_0000, 32'd4,        1'b0, 32'h0800_0000};
        vecs[1] = '{32'h8000_0000, 32'd4,        1'b1, 32'hF800_0000};
        vecs[2] = '{32'h7FFF_FFF0, 32'd4,        1'b1, 32'h07FF_FFFF};
        vecs[3] = '{32'hDEAD_BEEF, 32'd0,        1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{32'h8000_0000, 32'd31,       1'b1, 32'hFFFF_FFFF};
        vecs[5] = '{32'h8000_0000, 32'd31,       1'b0, 32'h0000_0001};
        vecs[6] = '{32'h0000_00F0, 32'h0000_0123, 1'b0, 32'h0000_001E};
        vecs[7] = '{32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b1, 32'hDEAD_BEEF};
        vecs[8] = '{32'h8000_0001, 32'd1,        1'b1, 32'hC000_0000};

        rst_n = 1'b0;
        START = 1'b0;
        A     = '0;
        B     = '0;
        ARITH = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_R",        R,               32'h0);
        check("reset_VALID",    {31'd0, VALID},    32'h0);
        check("reset_IN_READY", {31'd0, IN_READY}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with an always-ready consumer.
        bp_mode = 0;
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].ar, vecs[i].exp);
        drain();

        // Backpressure, plus requests issued while busy.
        bp_mode = 2;
        #0;
        OUT_READY = 1'b0;
        issue(32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
        pulse_junk();
        guard = 0;
        while (VALID !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_valid_seen", {31'd0, VALID}, 32'h1);
        pulse_junk();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid_hold", {31'd0, VALID}, 32'h1);
            check("bp_r_hold",     R,              32'h0800_0000);
            @(posedge clk);
            #1;
        end
        bp_mode = 0;
        drain();

        // Asynchronous reset in the middle of a shift.
        start_raw(32'hFFFF_0000, 32'd20, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_R",        R,                 32'h0);
        check("midreset_VALID",    {31'd0, VALID},    32'h0);
        check("midreset_IN_READY", {31'd0, IN_READY}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h0000_0010, 32'd4, 1'b0, 32'h0000_0001);
        drain();

        // Randomised operations with random consumer backpressure.
        bp_mode = 1;
        for (int n = 0; n < 300; n++) begin
            ra   = $urandom;
            rb   = $urandom;
            rar  = 1'($urandom_range(0, 1));
            rexp = rar ? WIDTH'($signed(ra) >>> rb[SHW-1:0]) : (ra >> rb[SHW-1:0]);
            issue(ra, rb, rar, rexp);
        end
        bp_mode = 0;
        drain();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
